// File: rtl/muxn1_pkg.sv
// Shared constants and helpers for the N:1 registered round-robin mux.
package muxn1_pkg;

   localparam logic MODE_FIXED = 1'b0;
   localparam logic MODE_RR    = 1'b1;

   // Index width for n channels, never narrower than one bit.
   function automatic int sel_w_f(input int n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/rr_arbiter_n.sv
// Round-robin arbiter: scans requests starting at the pointer and wraps.
// The pointer moves to one past the granted channel when adv is high.
module rr_arbiter_n
   import muxn1_pkg::*;
#(
   parameter int NUM_CH = 4,
   parameter int SEL_W  = sel_w_f(NUM_CH)
) (
   input  logic              clk,
   input  logic              reset_L,
   input  logic [NUM_CH-1:0] req,
   input  logic              adv,
   output logic [NUM_CH-1:0] gnt,
   output logic [SEL_W-1:0]  idx
);

   logic [SEL_W-1:0] ptr;

   // First requester at or after ptr, wrapping past the top channel.
   always_comb begin
      int   c;
      logic found;
      gnt   = '0;
      idx   = '0;
      found = 1'b0;
      c     = 0;
      for (int k = 0; k < NUM_CH; k++) begin
         c = int'(ptr) + k;
         if (c >= NUM_CH) c = c - NUM_CH;
         if (!found && req[SEL_W'(c)]) begin
            found            = 1'b1;
            gnt[SEL_W'(c)]   = 1'b1;
            idx              = SEL_W'(c);
         end
      end
   end

   // Pointer moves past the winner only when a transfer actually happens.
   always_ff @(posedge clk or negedge reset_L) begin
      if (!reset_L)
         ptr <= '0;
      else if (adv)
         ptr <= (idx == SEL_W'(NUM_CH-1)) ? '0 : idx + 1'b1;
   end

endmodule

// File: rtl/muxn1_rr_reg.sv
// N:1 registered mux with fixed-select or round-robin arbitration.
// One output stage, full throughput: a draining word and a new word can
// swap in the same cycle. Optional MUXN1_PARITY_EN adds parity_out.
module muxn1_rr_reg
   import muxn1_pkg::*;
#(
   parameter int NUM_CH = 4,
   parameter int DATA_W = 8,
   parameter int SEL_W  = sel_w_f(NUM_CH)
) (
   input  logic                     clk,
   input  logic                     reset_L,
   input  logic                     mode,
   input  logic [SEL_W-1:0]         selector,
   input  logic [NUM_CH*DATA_W-1:0] data_in,
   input  logic [NUM_CH-1:0]        valid_in,
   output logic [NUM_CH-1:0]        ready_out,
   output logic [DATA_W-1:0]        data_out,
   output logic                     valid_out,
   output logic [SEL_W-1:0]         ch_out,
   input  logic                     ready_in
`ifdef MUXN1_PARITY_EN
   ,
   output logic                     parity_out
`endif
);

   logic [NUM_CH-1:0][DATA_W-1:0] ch_data;
   logic [NUM_CH-1:0]             fix_gnt, rr_gnt, gnt;
   logic [SEL_W-1:0]              rr_idx, gnt_idx;
   logic                          load_en, xfer;

   assign ch_data = data_in;
   assign load_en = !valid_out || ready_in;

   // Fixed mode: only the selected channel may win; out-of-range selects match nothing.
   always_comb begin
      fix_gnt = '0;
      for (int i = 0; i < NUM_CH; i++)
         fix_gnt[i] = (selector == SEL_W'(i)) && valid_in[i];
   end

   assign gnt     = (mode == MODE_RR) ? rr_gnt : fix_gnt;
   assign gnt_idx = (mode == MODE_RR) ? rr_idx : selector;

   // Accept only when the output stage can take a word and reset is released.
   assign ready_out = (reset_L && load_en) ? gnt : '0;
   assign xfer      = |ready_out;

   rr_arbiter_n #(
      .NUM_CH (NUM_CH),
      .SEL_W  (SEL_W)
   ) u_arb (
      .clk     (clk),
      .reset_L (reset_L),
      .req     (valid_in),
      .adv     (xfer && (mode == MODE_RR)),
      .gnt     (rr_gnt),
      .idx     (rr_idx)
   );

   // Output stage: load on transfer, drain to empty when free, hold on stall.
   always_ff @(posedge clk or negedge reset_L) begin
      if (!reset_L) begin
         data_out   <= '0;
         ch_out     <= '0;
         valid_out  <= 1'b0;
`ifdef MUXN1_PARITY_EN
         parity_out <= 1'b0;
`endif
      end else if (xfer) begin
         data_out   <= ch_data[gnt_idx];
         ch_out     <= gnt_idx;
         valid_out  <= 1'b1;
`ifdef MUXN1_PARITY_EN
         parity_out <= ^ch_data[gnt_idx];
`endif
      end else if (load_en) begin
         valid_out  <= 1'b0;
      end
   end

endmodule

// File: tb/tb_muxn1_rr_reg.sv
// Bench for muxn1_rr_reg: directed vectors, literal spot checks and a
// per-cycle comparison against a behavioural model of the mux.
module tb_muxn1_rr_reg;
   localparam int NUM_CH = 4;
   localparam int DATA_W = 8;
   localparam int SEL_W  = 2;

   logic                          clk = 1'b0;
   logic                          reset_L;
   logic                          mode;
   logic [SEL_W-1:0]              selector;
   logic [NUM_CH-1:0][DATA_W-1:0] din;
   logic [NUM_CH-1:0]             valid_in;
   logic [NUM_CH-1:0]             ready_out;
   logic [DATA_W-1:0]             data_out;
   logic                          valid_out;
   logic [SEL_W-1:0]              ch_out;
   logic                          ready_in;
`ifdef MUXN1_PARITY_EN
   logic                          parity_out;
`endif

   int checks = 0;
   int errors = 0;

   muxn1_rr_reg #(.NUM_CH(NUM_CH), .DATA_W(DATA_W)) dut (
      .clk(clk), .reset_L(reset_L), .mode(mode), .selector(selector),
      .data_in(din), .valid_in(valid_in), .ready_out(ready_out),
      .data_out(data_out), .valid_out(valid_out), .ch_out(ch_out),
      .ready_in(ready_in)
`ifdef MUXN1_PARITY_EN
      , .parity_out(parity_out)
`endif
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   int          m_ptr   = 0;
   logic        m_valid = 1'b0;
   logic [7:0]  m_data  = '0;
   int          m_ch    = 0;
   logic        m_par   = 1'b0;

   // Channel that wins this cycle, or -1 if none.
   function automatic int m_grant();
      if (mode == 1'b0)
         return valid_in[selector] ? int'(selector) : -1;
      for (int k = 0; k < NUM_CH; k++) begin
         int c;
         c = (m_ptr + k) % NUM_CH;
         if (valid_in[c]) return c;
      end
      return -1;
   endfunction

   always @(posedge clk or negedge reset_L) begin
      int  g;
      logic room;
      if (!reset_L) begin
         m_ptr = 0; m_valid = 1'b0; m_data = '0; m_ch = 0; m_par = 1'b0;
      end else begin
         g    = m_grant();
         room = !m_valid || ready_in;
         if (room && g >= 0) begin
            m_valid = 1'b1;
            m_data  = din[g];
            m_ch    = g;
            m_par   = ^din[g];
            if (mode) m_ptr = (g + 1) % NUM_CH;
         end else if (room) begin
            m_valid = 1'b0;
         end
      end
   end

   // Every-cycle comparison, away from the rising edge.
   always @(negedge clk) begin
      int g;
      logic [NUM_CH-1:0] e_rdy;
      g     = m_grant();
      e_rdy = '0;
      if (reset_L && g >= 0 && (!m_valid || ready_in)) e_rdy = 4'(1) << g;
      chk("model valid_out", 32'(valid_out), 32'(m_valid));
      chk("model data_out",  32'(data_out),  32'(m_data));
      chk("model ch_out",    32'(ch_out),    32'(m_ch));
      chk("model ready_out", 32'(ready_out), 32'(e_rdy));
`ifdef MUXN1_PARITY_EN
      chk("model parity_out", 32'(parity_out), 32'(m_par));
`endif
   end

   // Step to just after the next rising edge (drive/check point).
   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   initial begin
      reset_L = 1'b0; mode = 1'b0; selector = '0; valid_in = '0;
      din = '0; ready_in = 1'b1;
      tick(); tick();
      chk("reset valid_out", 32'(valid_out), 0);
      chk("reset data_out",  32'(data_out),  0);
      chk("reset ch_out",    32'(ch_out),    0);
      chk("reset ready_out", 32'(ready_out), 0);
      reset_L = 1'b1;

      // Fixed select: channel 1 only, channel 0 never taken.
      din[0] = 8'h11; din[1] = 8'h22; selector = 2'd1; valid_in = 4'b0011;
      #1 chk("fixed ready_out", 32'(ready_out), 32'h2);
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("fixed data_out", 32'(data_out), 32'h22);
         chk("fixed ch_out",   32'(ch_out),   1);
         chk("fixed valid",    32'(valid_out), 1);
      end
      selector = 2'd3;
      tick();
      chk("fixed invalid sel valid", 32'(valid_out), 0);
      chk("fixed invalid sel hold",  32'(data_out),  32'h22);

      // Round-robin fairness, no bubbles.
      mode = 1'b1; valid_in = 4'b1111;
      for (int i = 0; i < NUM_CH; i++) din[i] = 8'(8'h40 + i);
      for (int i = 0; i < 8; i++) begin
         tick();
         chk("rr ch_out",   32'(ch_out),   32'(i % 4));
         chk("rr data_out", 32'(data_out), 32'(8'h40 + (i % 4)));
         chk("rr valid",    32'(valid_out), 1);
      end

      // Backpressure for three cycles, then back-to-back reload.
      ready_in = 1'b0;
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("stall ch_out",    32'(ch_out),    3);
         chk("stall data_out",  32'(data_out),  32'h43);
         chk("stall ready_out", 32'(ready_out), 0);
      end
      ready_in = 1'b1;
      #1 chk("release ready_out", 32'(ready_out), 32'h1);
      tick();
      chk("release ch_out", 32'(ch_out), 0);
      chk("release data",   32'(data_out), 32'h40);

      // Wrap/skip: grant ch2 so ptr=3, then 0101 yields ch0 then ch2.
      valid_in = 4'b0100;
      tick();
      chk("wrap pre ch_out", 32'(ch_out), 2);
      valid_in = 4'b0101;
      tick();
      chk("wrap ch0", 32'(ch_out), 0);
      tick();
      chk("wrap ch2", 32'(ch_out), 2);

      // Reset in the middle of a stall drops the held word.
      mode = 1'b0; selector = 2'd2; valid_in = 4'b0100; din[2] = 8'hA5;
      tick();
      chk("stall load data", 32'(data_out), 32'hA5);
      ready_in = 1'b0;
      tick();
      chk("stall held ch", 32'(ch_out), 2);
      reset_L = 1'b0;
      #1;
      chk("async clr valid", 32'(valid_out), 0);
      chk("async clr data",  32'(data_out),  0);
      chk("async clr ch",    32'(ch_out),    0);
      chk("async ready_out", 32'(ready_out), 0);
      tick();
      reset_L = 1'b1; valid_in = 4'b0000; ready_in = 1'b1;
      #1 chk("post reset ready", 32'(ready_out), 0);
      tick();
      chk("post reset valid", 32'(valid_out), 0);
      // Pointer restarted at 0: ch1 beats ch3.
      mode = 1'b1; valid_in = 4'b1010; din[1] = 8'h66; din[3] = 8'h77;
      #1 chk("ptr reset ready", 32'(ready_out), 32'h2);
      tick();
      chk("ptr reset ch", 32'(ch_out), 1);
      chk("ptr reset data", 32'(data_out), 32'h66);

`ifdef MUXN1_PARITY_EN
      mode = 1'b0; selector = 2'd0; valid_in = 4'b0001; din[0] = 8'h07;
      tick();
      chk("parity 07", 32'(parity_out), 1);
      din[0] = 8'h03;
      tick();
      chk("parity 03", 32'(parity_out), 0);
`endif

      valid_in = '0;
      tick(); tick();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
